// File: rtl/data_mov_unit.sv
// data_mov_unit: execute-stage data-movement unit (MV, LDW, STW, PUSH, POP).
// Owns the stack pointer and talks to memory over a req/ack handshake with
// a bounded wait. Every output is registered.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | waiting for start; operands latched and checks made on accept
// S_MEM  | mem_req held; waiting for mem_ack or the timeout
// S_DONE | one cycle to emit done/fault/reg_we, then back to S_IDLE
module data_mov_unit #(
    parameter int                 DATA_W      = 32,
    parameter int                 ADDR_W      = 32,
    parameter int                 IMM_W       = 16,
    parameter logic [ADDR_W-1:0]  STACK_BASE  = ADDR_W'(32'h0000_1000),
    parameter logic [ADDR_W-1:0]  STACK_LIMIT = ADDR_W'(32'h0000_0800),
    parameter int                 TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4:0]        opcode,
    input  logic              has_imm,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] x,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic              reg_we,
    output logic [DATA_W-1:0] y,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] rsp
);

    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [4:0] OP_LDW  = 5'b00001;
    localparam logic [4:0] OP_STW  = 5'b00010;
    localparam logic [4:0] OP_MV   = 5'b00011;
    localparam logic [4:0] OP_PUSH = 5'b10011;
    localparam logic [4:0] OP_POP  = 5'b10100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [4:0]         op_q, op_nxt;
    logic               err_q, err_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    logic               busy_nxt, done_nxt, fault_nxt, reg_we_nxt;
    logic [DATA_W-1:0]  y_nxt;
    logic               mem_req_nxt, mem_we_nxt;
    logic [ADDR_W-1:0]  mem_addr_nxt;
    logic [DATA_W-1:0]  mem_wdata_nxt;
    logic [ADDR_W-1:0]  rsp_nxt;

    logic [DATA_W-1:0]  src;
    logic [ADDR_W-1:0]  imm_addr;
    logic [ADDR_W-1:0]  rsp_dec;
    logic [ADDR_W-1:0]  rsp_inc;
    logic               is_wb_op;

    assign src      = has_imm ? DATA_W'(imm) : x;
    assign imm_addr = ADDR_W'(imm);
    assign rsp_dec  = rsp - ADDR_W'(BYTES);
    assign rsp_inc  = rsp + ADDR_W'(BYTES);
    assign is_wb_op = (op_q == OP_MV) || (op_q == OP_LDW) || (op_q == OP_POP);

    // State register plus all registered outputs; reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= '0;
            err_q     <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            reg_we    <= 1'b0;
            y         <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp       <= STACK_BASE;
        end else begin
            state     <= state_nxt;
            op_q      <= op_nxt;
            err_q     <= err_nxt;
            cnt       <= cnt_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            fault     <= fault_nxt;
            reg_we    <= reg_we_nxt;
            y         <= y_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            rsp       <= rsp_nxt;
        end
    end

    // Next-state decode and next values for every registered output.
    always_comb begin
        state_nxt     = state;
        op_nxt        = op_q;
        err_nxt       = err_q;
        cnt_nxt       = cnt;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        fault_nxt     = 1'b0;
        reg_we_nxt    = 1'b0;
        y_nxt         = y;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        rsp_nxt       = rsp;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    busy_nxt  = 1'b1;
                    op_nxt    = opcode;
                    err_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = S_DONE;
                    case (opcode)
                        OP_MV: begin
                            y_nxt = src;
                        end
                        OP_LDW: begin
                            mem_req_nxt  = 1'b1;
                            mem_we_nxt   = 1'b0;
                            mem_addr_nxt = imm_addr;
                            state_nxt    = S_MEM;
                        end
                        OP_STW: begin
                            mem_req_nxt   = 1'b1;
                            mem_we_nxt    = 1'b1;
                            mem_addr_nxt  = imm_addr;
                            mem_wdata_nxt = x;
                            state_nxt     = S_MEM;
                        end
                        OP_PUSH: begin
                            if (rsp_dec < STACK_LIMIT) begin
                                err_nxt = 1'b1;
                            end else begin
                                mem_req_nxt   = 1'b1;
                                mem_we_nxt    = 1'b1;
                                mem_addr_nxt  = rsp_dec;
                                mem_wdata_nxt = src;
                                state_nxt     = S_MEM;
                            end
                        end
                        OP_POP: begin
                            if (rsp >= STACK_BASE) begin
                                err_nxt = 1'b1;
                            end else begin
                                mem_req_nxt  = 1'b1;
                                mem_we_nxt   = 1'b0;
                                mem_addr_nxt = rsp;
                                state_nxt    = S_MEM;
                            end
                        end
                        default: begin
                            err_nxt = 1'b1;
                        end
                    endcase
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    state_nxt   = S_DONE;
                    if (op_q == OP_LDW || op_q == OP_POP) begin
                        y_nxt = mem_rdata;
                    end
                    if (op_q == OP_PUSH) begin
                        rsp_nxt = rsp_dec;
                    end else if (op_q == OP_POP) begin
                        rsp_nxt = rsp_inc;
                    end
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    mem_req_nxt = 1'b0;
                    err_nxt     = 1'b1;
                    state_nxt   = S_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DONE: begin
                done_nxt   = 1'b1;
                fault_nxt  = err_q;
                reg_we_nxt = is_wb_op && !err_q;
                busy_nxt   = 1'b0;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_mov_unit.sv
// Directed bench for data_mov_unit with hand-computed expectations.
module tb_data_mov_unit;

    localparam logic [4:0] OP_LDW  = 5'b00001;
    localparam logic [4:0] OP_STW  = 5'b00010;
    localparam logic [4:0] OP_MV   = 5'b00011;
    localparam logic [4:0] OP_PUSH = 5'b10011;
    localparam logic [4:0] OP_POP  = 5'b10100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  opcode;
    logic        has_imm;
    logic [15:0] imm;
    logic [31:0] x;
    logic        busy, done, fault, reg_we;
    logic [31:0] y;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [31:0] rsp;

    int n_cmp = 0;
    int n_err = 0;

    data_mov_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .has_imm(has_imm), .imm(imm), .x(x), .busy(busy), .done(done),
        .fault(fault), .reg_we(reg_we), .y(y), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rsp(rsp)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic hi, input logic [15:0] im, input logic [31:0] xv);
        opcode  = op;
        has_imm = hi;
        imm     = im;
        x       = xv;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Called in the first mem_req cycle; acks in mem_req cycle ack_at.
    task automatic ack_at_cycle(input int ack_at, input logic [31:0] rd);
        for (int i = 1; i < ack_at; i++) tick();
        mem_ack   = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ack   = 1'b0;
    endtask

    initial begin
        int faults_seen;
        int req_cycles;
        int done_seen;

        rst_n = 1'b0; start = 1'b0; opcode = '0; has_imm = 1'b0; imm = '0;
        x = '0; mem_rdata = '0; mem_ack = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_mem_req", 32'(mem_req), 32'd0);
        check_val("rst_rsp", rsp, 32'h0000_1000);
        check_val("rst_y", y, 32'h0);

        // MV immediate: done two cycles after start.
        issue(OP_MV, 1'b1, 16'h00AB, 32'hFFFF_FFFF);
        check_val("mv_c1_busy", 32'(busy), 32'd1);
        check_val("mv_c1_done", 32'(done), 32'd0);
        check_val("mv_c1_req", 32'(mem_req), 32'd0);
        tick();
        check_val("mv_done", 32'(done), 32'd1);
        check_val("mv_reg_we", 32'(reg_we), 32'd1);
        check_val("mv_fault", 32'(fault), 32'd0);
        check_val("mv_y", y, 32'h0000_00AB);
        check_val("mv_busy_low", 32'(busy), 32'd0);
        check_val("mv_rsp", rsp, 32'h0000_1000);
        tick();
        check_val("mv_done_pulse", 32'(done), 32'd0);

        // MV from register.
        issue(OP_MV, 1'b0, 16'h1111, 32'h55AA_55AA);
        tick();
        check_val("mvx_y", y, 32'h55AA_55AA);
        check_val("mvx_reg_we", 32'(reg_we), 32'd1);

        // Illegal opcode.
        issue(5'b11111, 1'b0, 16'h0, 32'h0);
        check_val("ill_req", 32'(mem_req), 32'd0);
        tick();
        check_val("ill_done", 32'(done), 32'd1);
        check_val("ill_fault", 32'(fault), 32'd1);
        check_val("ill_reg_we", 32'(reg_we), 32'd0);
        check_val("ill_y", y, 32'h55AA_55AA);

        // PUSH register, ack in the second mem_req cycle; later x change ignored.
        issue(OP_PUSH, 1'b0, 16'h1234, 32'hDEAD_BEEF);
        x = 32'h0;
        check_val("push_req", 32'(mem_req), 32'd1);
        check_val("push_we", 32'(mem_we), 32'd1);
        check_val("push_addr", mem_addr, 32'h0000_0FFC);
        check_val("push_wdata", mem_wdata, 32'hDEAD_BEEF);
        ack_at_cycle(2, 32'h0);
        check_val("push_req_drop", 32'(mem_req), 32'd0);
        check_val("push_rsp", rsp, 32'h0000_0FFC);
        tick();
        check_val("push_done", 32'(done), 32'd1);
        check_val("push_reg_we", 32'(reg_we), 32'd0);
        check_val("push_fault", 32'(fault), 32'd0);

        // POP back.
        issue(OP_POP, 1'b0, 16'h0, 32'h0);
        check_val("pop_addr", mem_addr, 32'h0000_0FFC);
        check_val("pop_we", 32'(mem_we), 32'd0);
        ack_at_cycle(1, 32'hDEAD_BEEF);
        tick();
        check_val("pop_done", 32'(done), 32'd1);
        check_val("pop_y", y, 32'hDEAD_BEEF);
        check_val("pop_reg_we", 32'(reg_we), 32'd1);
        check_val("pop_rsp", rsp, 32'h0000_1000);

        // POP on empty stack.
        issue(OP_POP, 1'b0, 16'h0, 32'h0);
        check_val("uf_req", 32'(mem_req), 32'd0);
        tick();
        check_val("uf_done", 32'(done), 32'd1);
        check_val("uf_fault", 32'(fault), 32'd1);
        check_val("uf_rsp", rsp, 32'h0000_1000);
        check_val("uf_y", y, 32'hDEAD_BEEF);

        // Fill the stack to STACK_LIMIT, then overflow.
        faults_seen = 0;
        for (int i = 0; i < 512; i++) begin
            issue(OP_PUSH, 1'b1, 16'(i), 32'h0);
            ack_at_cycle(1, 32'h0);
            tick();
            if (fault || !done) faults_seen++;
        end
        check_val("fill_faults", 32'(faults_seen), 32'd0);
        check_val("fill_rsp", rsp, 32'h0000_0800);
        issue(OP_PUSH, 1'b1, 16'hBEEF, 32'h0);
        check_val("of_req", 32'(mem_req), 32'd0);
        tick();
        check_val("of_done", 32'(done), 32'd1);
        check_val("of_fault", 32'(fault), 32'd1);
        check_val("of_rsp", rsp, 32'h0000_0800);

        // LDW timeout: mem_req high exactly 16 cycles.
        issue(OP_LDW, 1'b0, 16'h0040, 32'h0);
        check_val("to_addr", mem_addr, 32'h0000_0040);
        req_cycles = 0;
        while (mem_req && req_cycles < 40) begin
            req_cycles++;
            tick();
        end
        check_val("to_req_cycles", 32'(req_cycles), 32'd16);
        tick();
        check_val("to_done", 32'(done), 32'd1);
        check_val("to_fault", 32'(fault), 32'd1);
        check_val("to_reg_we", 32'(reg_we), 32'd0);
        check_val("to_y", y, 32'hDEAD_BEEF);

        // LDW with ack on the last timeout cycle: ack wins.
        issue(OP_LDW, 1'b0, 16'h0040, 32'h0);
        ack_at_cycle(16, 32'h1234_5678);
        tick();
        check_val("late_done", 32'(done), 32'd1);
        check_val("late_fault", 32'(fault), 32'd0);
        check_val("late_y", y, 32'h1234_5678);
        check_val("late_reg_we", 32'(reg_we), 32'd1);

        // STW, re-pulse start while busy, reset in MEM.
        issue(OP_STW, 1'b0, 16'h0080, 32'hCAFE_F00D);
        check_val("stw_we", 32'(mem_we), 32'd1);
        check_val("stw_addr", mem_addr, 32'h0000_0080);
        check_val("stw_wdata", mem_wdata, 32'hCAFE_F00D);
        issue(OP_MV, 1'b1, 16'h0077, 32'h0);
        check_val("rep_req", 32'(mem_req), 32'd1);
        check_val("rep_y", y, 32'h1234_5678);
        rst_n = 1'b0;
        tick();
        check_val("ar_req", 32'(mem_req), 32'd0);
        check_val("ar_busy", 32'(busy), 32'd0);
        check_val("ar_rsp", rsp, 32'h0000_1000);
        rst_n = 1'b1;
        done_seen = (done === 1'b1) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        check_val("ar_no_done", 32'(done_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mov_unit.md
Name: data_mov_unit

Overview:
Sequential data-movement execution unit. It executes MV, LDW, STW, PUSH and POP with a req/ack memory handshake. It owns the stack pointer and applies overflow/underflow checks and a memory timeout. It sits beside the ALU in the execute stage. Decode issues one instruction at a time via start/busy/done, and register writeback is signalled with a one-cycle reg_we pulse.

Parameters:
DATA_W, 32, data and register width; must be a multiple of 8
ADDR_W, 32, memory address width
IMM_W, 16, immediate width; zero-extended to DATA_W/ADDR_W
STACK_BASE, 32'h0000_1000, reset value of rsp (empty stack); stack grows down
STACK_LIMIT, 32'h0000_0800, lowest legal rsp value
TIMEOUT, 16, max cycles mem_req may stay high without mem_ack; must be >= 1

Ports:
clk  in  1  clock, all state changes on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  issue pulse; sampled only in IDLE
opcode  in  5  LDW=00001, STW=00010, MV=00011, PUSH=10011, POP=10100
has_imm  in  1  source is imm instead of x (MV, PUSH)
imm  in  IMM_W  immediate / absolute address (LDW, STW)
x  in  DATA_W  register operand
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
fault  out  1  valid with done: overflow, underflow, timeout or illegal opcode
reg_we  out  1  one-cycle pulse with done; y is valid to write back
y  out  DATA_W  writeback data, held until next accepted start
mem_req  out  1  memory request, held until mem_ack or timeout
mem_we  out  1  1 = write, 0 = read; valid while mem_req
mem_addr  out  ADDR_W  byte address; valid while mem_req
mem_wdata  out  DATA_W  store data; valid while mem_req and mem_we
mem_rdata  in  DATA_W  load data, sampled in the cycle mem_ack=1
mem_ack  in  1  memory completion; ignored unless mem_req=1
rsp  out  ADDR_W  current stack pointer

Behaviour:
- BYTES = DATA_W/8. src = has_imm ? zero-extend(imm) : x. Operands are latched on an accepted start; later input changes have no effect.
- Reset (rst_n=0 at an edge): state=IDLE, rsp=STACK_BASE, all other outputs 0. Reset mid-transaction aborts it: mem_req drops at that edge, rsp is not updated, and no done is produced.
- FSM states IDLE, MEM, DONE. All outputs are registered.
- IDLE + start: decode and check, then:
  - MV: y<=src, go to DONE.
  - Illegal opcode: fault path, go to DONE.
  - PUSH with rsp-BYTES < STACK_LIMIT (overflow): fault path, go to DONE.
  - POP with rsp >= STACK_BASE (underflow): fault path, go to DONE.
  - Otherwise load mem_addr/mem_we/mem_wdata, assert mem_req, go to MEM.
  - Fault path: fault<=1, reg_we=0, y unchanged, rsp unchanged, no memory request.
- Address and data per operation:
  - LDW: addr = zero-extend(imm), read.
  - STW: addr = zero-extend(imm), write x.
  - PUSH: addr = rsp-BYTES, write src.
  - POP: addr = rsp, read.
- MEM: a cycle counter starts at 0 on entry and increments each cycle with no ack.
  - mem_ack=1: drop mem_req. LDW/POP: y<=mem_rdata. PUSH: rsp<=rsp-BYTES. POP: rsp<=rsp+BYTES. Go to DONE.
  - Counter reaches TIMEOUT-1 with no ack: drop mem_req, set fault, leave rsp and y unchanged, go to DONE.
  - An ack arriving in the same cycle as the last timeout cycle wins; no fault.
- DONE: done=1 for one cycle. reg_we=1 only for MV/LDW/POP without fault. Then go to IDLE, where busy=0 and a new start may be accepted in the next cycle.
- start while busy or in DONE: ignored, with no queuing.
- Latency: MV and faults produce done 2 cycles after start. A memory op whose ack arrives k cycles after mem_req rises produces done at start+k+2.
- rsp arithmetic is modulo 2^ADDR_W, but the overflow/underflow checks prevent wrap within the legal range.

Test Plan:
1. Reset, then MV has_imm=1 imm=16'h00AB at cycle 0 -> done=1 and reg_we=1 at cycle 2, y=32'h000000AB, mem_req never asserted, rsp=32'h1000.
2. PUSH has_imm=0 x=32'hDEADBEEF, ack after 2 cycles -> mem_req with mem_we=1, mem_addr=32'h0FFC, mem_wdata=32'hDEADBEEF; after ack rsp=32'h0FFC, done with reg_we=0, fault=0.
3. Then POP, mem_rdata=32'hDEADBEEF on ack -> mem_addr=32'h0FFC, mem_we=0, y=32'hDEADBEEF, reg_we=1, rsp=32'h1000.
4. POP at rsp=32'h1000 -> done with fault=1 two cycles after start, no mem_req, rsp stays 32'h1000. Fill 512 PUSHes, then a 513th PUSH -> fault, rsp stays 32'h0800.
5. LDW imm=16'h0040 with mem_ack held low -> mem_req high exactly TIMEOUT=16 cycles, then fault=1 with done, y unchanged. Repeat with ack at cycle 16 -> no fault, y=mem_rdata.
6. STW issued, start re-pulsed while busy, rst_n=0 during MEM -> re-pulse ignored; at the reset edge mem_req=0, busy=0, rsp=STACK_BASE, and no done pulse.
